pa_ifu_sram_ctrl: RTL

PA_IFU_SRAM_CTRL -- requirements
Module: pa_ifu_sram_ctrl

---
 rtl/pa_ifu_sram_ctrl.sv | 102 ++++++++++
 1 files changed

// File: rtl/pa_ifu_sram_ctrl.sv
// IFU SRAM controller: arbitrates single-port SRAM access between a write and a
// read requester and runs a zero-fill sweep of every entry after reset or on request.
module pa_ifu_sram_ctrl #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 45
) (
  input  logic                  cpuclk,
  input  logic                  cpurst,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_gnt,
  output logic                  rd_vld,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DATA_WIDTH-1:0] wr_mask,
  output logic                  wr_gnt,
  input  logic                  inv_req,
  output logic                  inv_busy,
  output logic                  inv_done,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  typedef enum logic {SWEEP, IDLE} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] sweep_cnt, sweep_cnt_nxt;
  logic                  sweep_last;

  assign sweep_last = (sweep_cnt == {ADDR_WIDTH{1'b1}});
  assign inv_busy   = (state == SWEEP);
  assign rd_data    = sram_q;

  // NOTE: every signal gets a default before the case, so no path can leave one
  // unassigned and infer a latch.
  always_comb begin
    state_nxt     = state;
    sweep_cnt_nxt = sweep_cnt;
    rd_gnt        = 1'b0;
    wr_gnt        = 1'b0;
    sram_cen      = 1'b1;
    sram_gwen     = 1'b1;
    sram_wen      = {DATA_WIDTH{1'b1}};
    sram_a        = '0;
    sram_d        = '0;
    // During reset the SRAM stays deselected so no stray write can land.
    if (!cpurst) begin
      case (state)
        SWEEP: begin
          sram_cen      = 1'b0;
          sram_gwen     = 1'b0;
          sram_wen      = '0;
          sram_a        = sweep_cnt;
          sweep_cnt_nxt = sweep_cnt + 1'b1;
          if (sweep_last) state_nxt = IDLE;
        end
        IDLE: begin
          wr_gnt = wr_req;
          rd_gnt = rd_req & ~wr_req;
          if (wr_req) begin
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_a    = wr_addr;
            sram_d    = wr_data;
            sram_wen  = ~wr_mask;
          end else if (rd_req) begin
            sram_cen = 1'b0;
            sram_a   = rd_addr;
          end
          if (inv_req) begin
            state_nxt     = SWEEP;
            sweep_cnt_nxt = '0;
          end
        end
        default: state_nxt = SWEEP;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // values from before the edge, independent of statement order.
  always_ff @(posedge cpuclk) begin
    if (cpurst) begin
      state     <= SWEEP;
      sweep_cnt <= '0;
      rd_vld    <= 1'b0;
      inv_done  <= 1'b0;
    end else begin
      state     <= state_nxt;
      sweep_cnt <= sweep_cnt_nxt;
      rd_vld    <= rd_gnt;
      inv_done  <= (state == SWEEP) && sweep_last;
    end
  end

endmodule
